// File: rtl/dog_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dog_pixel_pipe
// Purpose  : Two-stage pixel pipeline for the dog sprite. Drives the sprite ROM
//            address, maps the returned index through a writable palette and
//            composites the result over the background colour.
// Options  : DOG_FLASH_EN - enables the laugh flash window, which inverts
//            opaque sprite colours for part of each 16-frame period.
// Revision : 1.0 - initial release
// ============================================================================
module dog_pixel_pipe #(
  parameter int ADDR_W       = 14,
  parameter int IDX_W        = 4,
  parameter int FLASH_FRAMES = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              is_dog,
  input  logic [ADDR_W-1:0] dog_addr,
  input  logic [23:0]       bg_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_waddr,
  input  logic [23:0]       pal_wdata,
  input  logic              laugh,
  output logic              out_valid,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic [23:0]       out_rgb,
  output logic              out_is_dog
);

  localparam int c_PAL_N = 1 << IDX_W;

  // Stage-1 registers: pixel attributes waiting for the ROM index
  logic              r_s1_valid;
  logic [9:0]        r_s1_x;
  logic [9:0]        r_s1_y;
  logic              r_s1_is_dog;
  logic [23:0]       r_s1_bg;

  // Palette storage
  logic [23:0]       r_pal [c_PAL_N];

  // Stage-2 combinational results
  logic              w_opaque;
  logic [23:0]       w_pal_rd;
  logic [23:0]       w_dog_rgb;
  logic [23:0]       w_rgb;
  logic              w_inv;

  // The ROM registers the address itself, so its data lines up with stage 1
  assign rom_addr = dog_addr;

  // Capture input pixel attributes into stage 1
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_is_dog <= 1'b0;
      r_s1_bg     <= '0;
    end else begin
      r_s1_valid  <= pix_valid;
      r_s1_x      <= DrawX;
      r_s1_y      <= DrawY;
      r_s1_is_dog <= is_dog;
      r_s1_bg     <= bg_rgb;
    end
  end

  // Palette write port; reads are combinational so a same-cycle read sees the old entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < c_PAL_N; i++) begin
        r_pal[i] <= '0;
      end
    end else if (pal_we) begin
      r_pal[pal_waddr] <= pal_wdata;
    end
  end

  // Index 0 is transparent whatever palette entry 0 holds
  assign w_pal_rd  = r_pal[rom_data];
  assign w_opaque  = r_s1_is_dog && (rom_data != '0);
  assign w_dog_rgb = w_inv ? ~w_pal_rd : w_pal_rd;
  assign w_rgb     = w_opaque ? w_dog_rgb : r_s1_bg;

  // Register the composited pixel and its stage-1 attributes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_rgb    <= '0;
      out_is_dog <= 1'b0;
    end else begin
      out_valid  <= r_s1_valid;
      out_x      <= r_s1_x;
      out_y      <= r_s1_y;
      out_rgb    <= w_rgb;
      out_is_dog <= w_opaque;
    end
  end

`ifdef DOG_FLASH_EN
  localparam logic [6:0] c_FLASH_LOAD = 7'(FLASH_FRAMES);

  logic       r_frame_clk_d;
  logic       r_fe;
  logic [6:0] r_flash_cnt;

  // Turn the slow frame strobe level into a single-cycle frame pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_clk_d <= 1'b0;
      r_fe          <= 1'b0;
    end else begin
      r_frame_clk_d <= frame_clk;
      r_fe          <= frame_clk && !r_frame_clk_d;
    end
  end

  // Flash window counter: a laugh (re)loads, each frame counts down to zero
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_flash_cnt <= '0;
    end else if (laugh) begin
      r_flash_cnt <= c_FLASH_LOAD;
    end else if (r_fe && (r_flash_cnt != '0)) begin
      r_flash_cnt <= r_flash_cnt - 7'd1;
    end
  end

  // Bit 3 gives an 8-frames-on / 8-frames-off blink inside the window
  assign w_inv = (r_flash_cnt != '0) && r_flash_cnt[3];
`else
  // Flash inputs have no function in this build
  logic w_unused_flash;
  assign w_unused_flash = ^{frame_clk, laugh, (FLASH_FRAMES != 0)};
  assign w_inv          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dog_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dog_pixel_pipe
// Purpose  : Self-checking bench for dog_pixel_pipe. A cycle-history model
//            predicts every output; directed literals pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dog_pixel_pipe;
  localparam int MAXC = 8192;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        is_dog = 1'b0;
  logic [13:0] dog_addr = '0;
  logic [23:0] bg_rgb = '0;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_waddr = '0;
  logic [23:0] pal_wdata = '0;
  logic        laugh = 1'b0;
  logic        out_valid;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic [23:0] out_rgb;
  logic        out_is_dog;

  dog_pixel_pipe #(.ADDR_W(14), .IDX_W(4), .FLASH_FRAMES(64)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .is_dog(is_dog), .dog_addr(dog_addr),
    .bg_rgb(bg_rgb), .rom_addr(rom_addr), .rom_data(rom_data),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .laugh(laugh), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .out_rgb(out_rgb), .out_is_dog(out_is_dog)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle history of everything the DUT saw; cycle c is the interval after edge c+1
  logic        h_rst   [MAXC];
  logic        h_valid [MAXC];
  logic [9:0]  h_x     [MAXC];
  logic [9:0]  h_y     [MAXC];
  logic        h_dog   [MAXC];
  logic [23:0] h_bg    [MAXC];
  logic [3:0]  h_rom   [MAXC];
  logic [23:0] h_palrd [MAXC];
  logic        h_inv   [MAXC];
  logic        h_fcl   [MAXC];
  logic [23:0] m_pal   [16];
  int          m_fc = 0;

  // Model: output seen in cycle c is the pixel presented in cycle c-2,
  // coloured by the ROM index and palette contents of cycle c-1.
  always @(negedge Clk) begin
    logic [23:0] e_rgb;
    logic        e_v, e_d, e_fe;
    logic [9:0]  e_x, e_y;
    if (cyc < MAXC) begin
      if (cyc < 2 || h_rst[cyc-1] || h_rst[cyc-2]) begin
        e_v = 1'b0; e_x = '0; e_y = '0; e_d = 1'b0; e_rgb = '0;
      end else begin
        e_v   = h_valid[cyc-2];
        e_x   = h_x[cyc-2];
        e_y   = h_y[cyc-2];
        e_d   = h_dog[cyc-2] && (h_rom[cyc-1] != 4'd0);
        e_rgb = e_d ? (h_palrd[cyc-1] ^ {24{h_inv[cyc-1]}}) : h_bg[cyc-2];
      end
      if (cyc >= 2) begin
        chk("out_valid", 32'(out_valid), 32'(e_v));
        chk("out_x", 32'(out_x), 32'(e_x));
        chk("out_y", 32'(out_y), 32'(e_y));
        chk("out_is_dog", 32'(out_is_dog), 32'(e_d));
        chk("out_rgb", 32'(out_rgb), 32'(e_rgb));
        chk("rom_addr", 32'(rom_addr), 32'(dog_addr));
      end
      h_rst[cyc]   = Reset;
      h_valid[cyc] = pix_valid;
      h_x[cyc]     = DrawX;
      h_y[cyc]     = DrawY;
      h_dog[cyc]   = is_dog;
      h_bg[cyc]    = bg_rgb;
      h_rom[cyc]   = rom_data;
      h_palrd[cyc] = m_pal[rom_data];
      h_fcl[cyc]   = frame_clk;
`ifdef DOG_FLASH_EN
      h_inv[cyc]   = (m_fc != 0) && (((m_fc / 8) % 2) == 1);
`else
      h_inv[cyc]   = 1'b0;
`endif
      // One frame pulse per rising frame strobe, arriving two cycles after the rise
      e_fe = (cyc >= 2) && h_fcl[cyc-1] && !h_fcl[cyc-2] && !h_rst[cyc-1];
      if (Reset) begin
        for (int i = 0; i < 16; i++) m_pal[i] = '0;
        m_fc = 0;
      end else begin
        if (pal_we) m_pal[pal_waddr] = pal_wdata;
        if (laugh) m_fc = 64;
        else if (e_fe && m_fc > 0) m_fc = m_fc - 1;
      end
    end
    cyc++;
  end

  logic [3:0] next_rom = '0;

  // Present one pixel for one cycle; the ROM answer for it appears the next cycle
  task automatic px(input logic v, input int x, input int y, input logic d,
                    input logic [13:0] a, input logic [23:0] bg, input logic [3:0] rv,
                    input logic we = 1'b0, input logic [3:0] wa = 4'd0,
                    input logic [23:0] wd = 24'd0);
    rom_data  = next_rom;
    pix_valid = v;
    DrawX     = 10'(x);
    DrawY     = 10'(y);
    is_dog    = d;
    dog_addr  = a;
    bg_rgb    = bg;
    pal_we    = we;
    pal_waddr = wa;
    pal_wdata = wd;
    next_rom  = d ? rv : 4'($urandom);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_rgb", 32'(out_rgb), 32'h0);
    chk("rst_is_dog", 32'(out_is_dog), 32'h0);
    Reset = 1'b0;

    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0, 1'b1, 4'd1, 24'hA0522D);
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0, 1'b1, 4'd5, 24'h101010);

    // Opaque pixel, then a dog pixel with transparent index 0
    px(1'b1, 10, 20, 1'b1, 14'h0123, 24'h111111, 4'd1);
    chk("rom_addr_lit", 32'(rom_addr), 32'h0123);
    px(1'b1, 11, 20, 1'b1, 14'h0124, 24'h3CBCFC, 4'd0);
    chk("t1_rgb", 32'(out_rgb), 32'hA0522D);
    chk("t1_is_dog", 32'(out_is_dog), 32'h1);
    chk("t1_x", 32'(out_x), 32'd10);
    chk("t1_y", 32'(out_y), 32'd20);
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0);
    chk("t2_rgb", 32'(out_rgb), 32'h3CBCFC);
    chk("t2_is_dog", 32'(out_is_dog), 32'h0);

    // Non-dog pixels with random ROM data always show the background
    for (int i = 0; i < 20; i++)
      px(1'b1, i, 21, 1'b0, 14'(i), 24'($urandom), 4'd0);
    px(1'b1, 50, 22, 1'b0, 14'h5, 24'h0A0B0C, 4'd0);
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0);
    chk("bg_only_rgb", 32'(out_rgb), 32'h0A0B0C);

    // Palette write colliding with a read of the same entry
    px(1'b1, 30, 40, 1'b1, 14'h10, 24'h222222, 4'd5);
    px(1'b1, 31, 40, 1'b1, 14'h11, 24'h222222, 4'd5, 1'b1, 4'd5, 24'hFFFFFF);
    chk("rw_old_rgb", 32'(out_rgb), 32'h101010);
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0);
    chk("rw_new_rgb", 32'(out_rgb), 32'hFFFFFF);

    // 640-pixel line with valid dropping every third cycle
    for (int i = 0; i < 640; i++)
      px((i % 3) != 2, i, 100, i[0], 14'(i), 24'(i * 37), 4'($urandom));

    // Reset with valid pixels in flight
    px(1'b1, 300, 5, 1'b1, 14'h1, 24'h333333, 4'd1);
    px(1'b1, 301, 5, 1'b1, 14'h2, 24'h333333, 4'd5);
    Reset = 1'b1;
    px(1'b1, 302, 5, 1'b1, 14'h3, 24'h333333, 4'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_rgb", 32'(out_rgb), 32'h0);
    chk("mid_rst_x", 32'(out_x), 32'h0);
    Reset = 1'b0;
    px(1'b1, 200, 7, 1'b1, 14'h4, 24'h444444, 4'd1);
    chk("post_rst_stale", 32'(out_valid), 32'h0);
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    chk("post_rst_x", 32'(out_x), 32'd200);
    chk("post_rst_pal_cleared", 32'(out_rgb), 32'h0);
    chk("post_rst_is_dog", 32'(out_is_dog), 32'h1);

`ifdef DOG_FLASH_EN
    // Laugh window over 100 frames with a restart at frame 30
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0, 1'b1, 4'd1, 24'h00FF00);
    laugh = 1'b1;
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0);
    laugh = 1'b0;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 20; k++) begin
        frame_clk = (k < 10);
        laugh = (f == 30) && (k == 0);
        px(1'b1, k, f, 1'b1, 14'h7, 24'h123456, 4'd1);
      end
    end
    laugh = 1'b0;
    frame_clk = 1'b0;
    px(1'b1, 0, 0, 1'b1, 14'h7, 24'h123456, 4'd1);
    px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0);
    chk("flash_steady_rgb", 32'(out_rgb), 32'h00FF00);
`endif

    repeat (3) px(1'b0, 0, 0, 1'b0, 14'h0, 24'h0, 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
